nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 62 ++++++
 tb/tb_nibble_serial_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES-wide operands one nibble per cycle
// through an external combinational 4-bit adder, with valid/ready handshakes.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [4*NIBBLES-1:0] a_q, b_q;
  logic [2:0] idx;
  logic carry, run, last;
  assign run  = state == RUN;
  assign last = idx == 3'(NIBBLES-1);
  assign cout = carry;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= op_a;
      b_q   <= op_b;
      carry <= cin;
      idx   <= '0;
    end else if (run) begin
      result[4*idx +: 4] <= add_sum;
      carry              <= add_cout;
      idx                <= idx + 3'd1;
    end
  always_comb begin
    state_nx  = (state == IDLE && in_valid)  ? RUN  :
                (run && last)                ? DONE :
                (state == DONE && out_ready) ? IDLE :
                (state == RUN || state == DONE) ? state : IDLE;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    add_a     = run ? a_q[4*idx +: 4] : 4'd0;
    add_b     = run ? b_q[4*idx +: 4] : 4'd0;
    add_cin   = run & carry;
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors with a queue scoreboard checked by
// a monitor whenever a result is handed over.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, add_cin, add_cout;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  logic [3:0] add_a, add_b, add_sum;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [W:0] exp_q[$];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
  );

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else chk("sum", {15'd0, cout, result}, {15'd0, exp_q.pop_front()});
    end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    chk("accept_ready", in_ready, 1);
    op_a = a; op_b = b; cin = c; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c));
  endtask

  task automatic track(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] part;
    logic [W-1:0] mask;
    for (int j = 0; j < N; j++) begin
      mask = W'((1 << (4*j)) - 1);
      part = {1'b0, a & mask} + {1'b0, b & mask} + (W+1)'(c);
      chk("add_a", {28'd0, add_a}, {28'd0, a[4*j +: 4]});
      chk("add_b", {28'd0, add_b}, {28'd0, b[4*j +: 4]});
      chk("add_cin", {31'd0, add_cin}, {31'd0, part[4*j]});
      chk("run_out_valid", {31'd0, out_valid}, 0);
      chk("run_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    chk("latency_out_valid", {31'd0, out_valid}, 1);
    chk("done_add_cin", {31'd0, add_cin}, 0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start(a, b, c);
    track(a, b, c);
    @(posedge clk); #1;
    chk("back_to_idle", {31'd0, in_ready}, 1);
  endtask

  task automatic accept_when_ready(output int t);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 1);
    exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin));
    @(posedge clk); #1;
    t = cyc;
  endtask

  initial begin
    logic [W-1:0] r;
    logic c;
    int t0, t1, t2;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_add", {23'd0, add_a, add_b, add_cin}, 0);
    #20 rst_n = 1;
    op(16'h1234, 16'h1111, 0);
    op(16'hFFFF, 16'h0001, 0);
    op(16'hFFFF, 16'h0000, 1);
    op(16'h8000, 16'h8000, 0);
    op(16'hA5C3, 16'h5A3C, 1);
    out_ready = 0;
    start(16'h0F0F, 16'h0101, 1);
    track(16'h0F0F, 16'h0101, 1);
    r = result; c = cout;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; op_a = 16'hDEAD + W'(k); op_b = 16'hBEEF; cin = 1;
      @(posedge clk); #1;
      chk("hold_result", {16'd0, result}, {16'd0, r});
      chk("hold_cout", {31'd0, cout}, {31'd0, c});
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 1);
    chk("idle_result_kept", {16'd0, result}, {16'd0, r});
    start(16'h1234, 16'h4321, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_result", {16'd0, result}, 0);
    chk("abort_cout", {31'd0, cout}, 0);
    chk("abort_add", {23'd0, add_a, add_b, add_cin}, 0);
    #3 rst_n = 1;
    #1;
    op(16'h0001, 16'h0001, 0);
    op_a = 16'h1111; op_b = 16'h2222; cin = 0; in_valid = 1;
    accept_when_ready(t0);
    op_a = 16'hFFFF; op_b = 16'h0002; cin = 1;
    accept_when_ready(t1);
    op_a = 16'h7777; op_b = 16'h8888; cin = 1;
    accept_when_ready(t2);
    in_valid = 0;
    chk("b2b_gap1", t1 - t0, 6);
    chk("b2b_gap2", t2 - t1, 6);
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
